// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, flag layout.
package alu_pkg;

    typedef enum logic [2:0] {
        RA       = 3'd0,
        RB       = 3'd1,
        RADD     = 3'd2,
        RSUB     = 3'd3,
        BEQ      = 3'd4,
        BNE      = 3'd5,
        MULL_FLT = 3'd6,
        MULL_INT = 3'd7
    } func_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Bit positions inside the {V,N,Z,C} flags word
    localparam int FLAG_V = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    function automatic logic is_mul(input logic [2:0] f);
        return (f == MULL_FLT) || (f == MULL_INT);
    endfunction

    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic z, input logic c);
        logic [3:0] f;
        f         = '0;
        f[FLAG_V] = v;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative unsigned shift-add multiplier: one partial product per clock.
// After load, exactly N iterations are performed; last is high during the
// N-th one. Once the multiplier register is exhausted the product holds.
module seq_mult #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           nReset,
    input  logic           load,
    input  logic [N-1:0]   mag_a,
    input  logic [N-1:0]   mag_b,
    output logic [2*N-1:0] product,
    output logic           last
);

    localparam int CW = $clog2(N + 1);

    logic [2*N-1:0] mcand_q;
    logic [2*N-1:0] prod_q;
    logic [N-1:0]   mplier_q;
    logic [CW-1:0]  count_q;

    // Load operands, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk) begin
        if (!nReset) begin
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else if (load) begin
            mcand_q  <= {{N{1'b0}}, mag_a};
            prod_q   <= '0;
            mplier_q <= mag_b;
            count_q  <= '0;
        end else begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (count_q != CW'(N)) begin
                count_q <= count_q + CW'(1);
            end
        end
    end

    assign product = prod_q;
    assign last    = (count_q == CW'(N - 1));

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/compare ops and an iterative
// signed multiply (integer low half or Q1.(N-1) fractional with saturation).
module seq_alu
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         nReset,
    input  logic         start,
    input  logic [2:0]   func,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    state_e         state_q, state_d;
    logic [N-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;
    logic           done_q, done_d;
    logic           sign_q, sign_d;
    logic           flt_q, flt_d;

    logic           load;
    logic [N-1:0]   mag_a, mag_b;
    logic [2*N-1:0] product;
    logic           last;

    logic [N:0]     sum_w, diff_w;
    logic [N-1:0]   op_res;
    logic           op_v, op_c;

    logic [2*N-1:0] prod_s;
    logic [N-1:0]   frac;
    logic           neg_ovf;
    logic [N-1:0]   mul_res;
    logic           mul_v;

    // Two's-complement magnitudes; the most negative value maps to 2^(N-1)
    assign mag_a = a[N-1] ? -a : a;
    assign mag_b = b[N-1] ? -b : b;

    seq_mult #(.N(N)) u_mult (
        .clk     (clk),
        .nReset  (nReset),
        .load    (load),
        .mag_a   (mag_a),
        .mag_b   (mag_b),
        .product (product),
        .last    (last)
    );

    assign sum_w  = {1'b0, a} + {1'b0, b};
    assign diff_w = {1'b0, a} - {1'b0, b};

    // Single-cycle operation result and V/C flags
    always_comb begin
        op_res = a;
        op_v   = 1'b0;
        op_c   = 1'b0;
        case (func_e'(func))
            RA:   op_res = a;
            RB:   op_res = b;
            RADD: begin
                op_res = sum_w[N-1:0];
                op_c   = sum_w[N];
                op_v   = (a[N-1] == b[N-1]) && (sum_w[N-1] != a[N-1]);
            end
            RSUB: begin
                op_res = diff_w[N-1:0];
                op_c   = diff_w[N];
                op_v   = (a[N-1] != b[N-1]) && (diff_w[N-1] != a[N-1]);
            end
            BEQ:  op_res = (a == b) ? '0 : a;
            BNE:  op_res = (a != b) ? N'(1) : a;
            default: op_res = a;
        endcase
    end

    assign prod_s  = sign_q ? -product : product;
    assign frac    = product[2*N-2:N-1];
    // A negative product overflows only when its magnitude exceeds 2^(N-1)
    assign neg_ovf = (|product[2*N-1:N]) || (product[N-1] && (|product[N-2:0]));

    // Sign correction and formatting of the finished magnitude product
    always_comb begin
        mul_res = '0;
        mul_v   = 1'b0;
        if (flt_q) begin
            if (sign_q) begin
                mul_res = -frac;
            end else if (frac[N-1]) begin
                mul_res = {1'b0, {(N-1){1'b1}}};
                mul_v   = 1'b1;
            end else begin
                mul_res = frac;
            end
        end else begin
            mul_res = prod_s[N-1:0];
            mul_v   = sign_q ? neg_ovf : (|product[2*N-1:N-1]);
        end
    end

    // Next-state and output register updates
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        sign_d   = sign_q;
        flt_d    = flt_q;
        load     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_mul(func)) begin
                        load    = 1'b1;
                        sign_d  = a[N-1] ^ b[N-1];
                        flt_d   = (func == MULL_FLT);
                        state_d = S_MUL;
                    end else begin
                        result_d = op_res;
                        flags_d  = pack_flags(op_v, op_res[N-1], op_res == '0, op_c);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (last) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = mul_res;
                flags_d  = pack_flags(mul_v, mul_res[N-1], mul_res == '0, 1'b0);
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            sign_q   <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            sign_q   <= sign_d;
            flt_q    <= flt_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign flags  = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu with N=8.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int N = 8;

    logic         clk;
    logic         nReset;
    logic         start;
    logic [2:0]   func;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [3:0]   flags;

    int checks   = 0;
    int failures = 0;

    int done_at, busy_cnt, done_cnt;
    logic         busy_r;
    logic [N-1:0] result_r;
    logic [3:0]   flags_r;

    seq_alu #(.N(N)) dut (
        .clk    (clk),
        .nReset (nReset),
        .start  (start),
        .func   (func),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch a fixed 14-edge window; edge k=1 is the sampling edge
    task automatic do_op(input logic [2:0] f, input logic [N-1:0] x, input logic [N-1:0] y,
                         output int d_at, output int b_cnt, output int d_cnt);
        start = 1'b1; func = f; a = x; b = y;
        d_at = 0; b_cnt = 0; d_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (busy) b_cnt++;
            if (done) begin
                d_cnt++;
                if (d_at == 0) d_at = k;
            end
        end
    endtask

    initial begin
        nReset = 1'b0; start = 1'b0; func = 3'd0; a = '0; b = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy",   busy,   0);
        check("rst_done",   done,   0);
        check("rst_result", result, 0);
        check("rst_flags",  flags,  0);
        nReset = 1'b1;
        @(posedge clk); #1;

        // RADD signed overflow
        do_op(RADD, 8'h7F, 8'h01, done_at, busy_cnt, done_cnt);
        check("radd_ovf_done_at", done_at,  1);
        check("radd_ovf_busy",    busy_cnt, 0);
        check("radd_ovf_dcnt",    done_cnt, 1);
        check("radd_ovf_res",     result,   8'h80);
        check("radd_ovf_flags",   flags,    4'b1100);

        // RADD carry out, zero result
        do_op(RADD, 8'hFF, 8'h01, done_at, busy_cnt, done_cnt);
        check("radd_c_res",   result, 8'h00);
        check("radd_c_flags", flags,  4'b0011);

        // RSUB borrow
        do_op(RSUB, 8'h00, 8'h01, done_at, busy_cnt, done_cnt);
        check("rsub_b_done_at", done_at, 1);
        check("rsub_b_res",     result,  8'hFF);
        check("rsub_b_flags",   flags,   4'b0101);

        // RSUB signed overflow
        do_op(RSUB, 8'h80, 8'h01, done_at, busy_cnt, done_cnt);
        check("rsub_v_res",   result, 8'h7F);
        check("rsub_v_flags", flags,  4'b1000);

        do_op(BEQ, 8'h33, 8'h33, done_at, busy_cnt, done_cnt);
        check("beq_eq_res",   result, 8'h00);
        check("beq_eq_flags", flags,  4'b0010);

        do_op(BEQ, 8'h90, 8'h01, done_at, busy_cnt, done_cnt);
        check("beq_ne_res",   result, 8'h90);
        check("beq_ne_flags", flags,  4'b0100);

        do_op(BNE, 8'h12, 8'h34, done_at, busy_cnt, done_cnt);
        check("bne_ne_res",   result, 8'h01);
        check("bne_ne_flags", flags,  4'b0000);

        do_op(BNE, 8'h55, 8'h55, done_at, busy_cnt, done_cnt);
        check("bne_eq_res",   result, 8'h55);
        check("bne_eq_flags", flags,  4'b0000);

        do_op(RA, 8'h80, 8'h11, done_at, busy_cnt, done_cnt);
        check("ra_res",   result, 8'h80);
        check("ra_flags", flags,  4'b0100);

        do_op(RB, 8'h80, 8'h00, done_at, busy_cnt, done_cnt);
        check("rb_res",   result, 8'h00);
        check("rb_flags", flags,  4'b0010);

        // MULL_INT -3 * 5 = -15
        do_op(MULL_INT, 8'hFD, 8'h05, done_at, busy_cnt, done_cnt);
        check("mint_done_at", done_at,  10);
        check("mint_busy",    busy_cnt, 9);
        check("mint_dcnt",    done_cnt, 1);
        check("mint_res",     result,   8'hF1);
        check("mint_flags",   flags,    4'b0100);

        // MULL_INT 16 * 16 overflows and wraps to zero
        do_op(MULL_INT, 8'h10, 8'h10, done_at, busy_cnt, done_cnt);
        check("mint_ovf_done_at", done_at, 10);
        check("mint_ovf_res",     result,  8'h00);
        check("mint_ovf_flags",   flags,   4'b1010);

        // MULL_FLT 0.5 * -0.5 = -0.25
        do_op(MULL_FLT, 8'h40, 8'hC0, done_at, busy_cnt, done_cnt);
        check("mflt_done_at", done_at, 10);
        check("mflt_res",     result,  8'hE0);
        check("mflt_flags",   flags,   4'b0100);

        // MULL_FLT -1 * -1 saturates
        do_op(MULL_FLT, 8'h80, 8'h80, done_at, busy_cnt, done_cnt);
        check("mflt_sat_res",   result, 8'h7F);
        check("mflt_sat_flags", flags,  4'b1000);

        // Start during a multiply is ignored
        start = 1'b1; func = MULL_INT; a = 8'hFD; b = 8'h05;
        done_at = 0; done_cnt = 0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 2) begin start = 1'b1; func = RADD; a = 8'h7F; b = 8'h01; end
            if (k == 3) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
        check("ign_done_at", done_at, 10);
        check("ign_dcnt",    done_cnt, 1);
        check("ign_res",     result,  8'hF1);
        check("ign_flags",   flags,   4'b0100);

        // Back-to-back: new start accepted while done is high
        start = 1'b1; func = MULL_INT; a = 8'hFD; b = 8'h05;
        done_at = 0; done_cnt = 0;
        result_r = '0; flags_r = '0;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = k;
                    start = 1'b1; func = RADD; a = 8'h7F; b = 8'h01;
                end
            end
            if (done_at != 0 && k == done_at + 1) begin
                start = 1'b0;
                result_r = result;
                flags_r  = flags;
            end
        end
        check("b2b_dcnt",  done_cnt, 2);
        check("b2b_res",   result_r, 8'h80);
        check("b2b_flags", flags_r,  4'b1100);

        // Reset aborts an in-flight multiply
        do_op(MULL_FLT, 8'h80, 8'h80, done_at, busy_cnt, done_cnt);
        start = 1'b1; func = MULL_INT; a = 8'h10; b = 8'h10;
        done_cnt = 0; busy_r = 1'b1; result_r = '1; flags_r = '1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (k == 4) nReset = 1'b0;
            if (k == 5) begin
                busy_r = busy; result_r = result; flags_r = flags;
                nReset = 1'b1;
            end
            if (k >= 5 && done) done_cnt++;
        end
        check("abort_busy",   busy_r,   0);
        check("abort_result", result_r, 0);
        check("abort_flags",  flags_r,  0);
        check("abort_dcnt",   done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits (N >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port nReset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled with func/a/b only when busy=0.
REQ-005 SHALL have port func  input  3  operation code from alu_pkg.
REQ-006 SHALL have ports a and b  input  N  signed two's-complement operands.
REQ-007 SHALL have port busy  output  1  high while a multiply is in progress.
REQ-008 SHALL have port done  output  1  single-cycle pulse when result/flags are updated.
REQ-009 SHALL have port result  output  N  registered result, held until the next done.
REQ-010 SHALL have port flags  output  4  registered {V,N,Z,C}, held until the next done.

Function
REQ-011 SHALL implement these codes: RA=0 (a), RB=1 (b), RADD=2, RSUB=3, BEQ=4, BNE=5, MULL_FLT=6, MULL_INT=7.
REQ-012 SHALL complete RA/RB/RADD/RSUB/BEQ/BNE in one cycle: start at edge t gives done=1, busy=0 at edge t+1.
REQ-013 SHALL compute RADD as a+b mod 2^N; V = signed overflow; C = carry out of bit N-1.
REQ-014 SHALL compute RSUB as a-b mod 2^N; V = signed overflow; C = borrow, i.e. inverted carry (picoMIPS convention).
REQ-015 SHALL return 0 for BEQ when a==b, else a; SHALL return 1 for BNE when a!=b, else a; V=C=0 for both.
REQ-016 SHALL update N=result[N-1] and Z=(result==0) on every done; V=C=0 for RA, RB and multiplies unless stated.
REQ-017 SHALL execute multiplies through FSM IDLE -> MUL -> FIX -> IDLE: IDLE loads |a|, |b| and sign=a[N-1]^b[N-1]; MUL runs exactly N shift-add iterations on magnitudes; FIX applies the sign and formats the result.
REQ-018 SHALL assert busy from edge t+1 through edge t+N+1 and pulse done at edge t+N+2 for a multiply started at edge t.
REQ-019 SHALL treat the magnitude of the most negative value (1 followed by N-1 zeros) as 2^(N-1) unsigned.
REQ-020 SHALL return signed product bits [N-1:0] (wrap) for MULL_INT; V=1 when the true product lies outside [-2^(N-1), 2^(N-1)-1].
REQ-021 SHALL return Q1.(N-1) product bits [2N-2:N-1] for MULL_FLT, then sign-correct (truncate toward zero); when a positive result overflows, SHALL saturate to 2^(N-1)-1 and set V=1.
REQ-022 SHALL ignore start while busy=1; the in-flight operation SHALL be unaffected.
REQ-023 SHALL accept a new start in the same cycle done is high (back-to-back operation).
REQ-024 SHALL treat an undefined func as RA.

Reset
REQ-025 SHALL, on any clk edge with nReset=0, set state=IDLE, busy=0, done=0, result=0, flags=0, and clear the iteration counter.
REQ-026 SHALL abort an in-flight multiply on reset; done SHALL NOT pulse for the aborted operation.

Structure
REQ-027 SHALL place the func code constants, the FSM state enum and the flag bit indices (V=3, N=2, Z=1, C=0) in shared package alu_pkg.
REQ-028 SHALL implement the iterative unsigned shift-add core as sub-module seq_mult, with ports clk, nReset, load, mag_a, mag_b, product[2N-1:0], last.

Verification (N=8)
REQ-029 SHALL verify RADD a=0x7F, b=0x01 -> result 0x80, flags V=1 N=1 Z=0 C=0, done at t+1.
REQ-030 SHALL verify RSUB a=0x00, b=0x01 -> result 0xFF, flags N=1 C=1 V=0; and BEQ a=b=0x33 -> result 0x00, Z=1.
REQ-031 SHALL verify MULL_INT a=0xFD (-3), b=0x05 -> result 0xF1, V=0, busy for 9 cycles, done at t+10; and a=0x10, b=0x10 -> result 0x00, V=1, Z=1.
REQ-032 SHALL verify MULL_FLT a=0x40, b=0xC0 -> result 0xE0; and a=0x80, b=0x80 -> result 0x7F, V=1.
REQ-033 SHALL verify that a start with RADD at t+3 during a multiply is ignored (single done at t+10 with the product), and that nReset=0 at t+5 gives busy=0, result=0, flags=0 with no done pulse afterwards.
